// File: rtl/ysyx_23060203_ifu_pkg.sv
// Shared constants for the instruction fetch unit: boot address and fault codes
// reported alongside each fetched instruction.
package ysyx_23060203_ifu_pkg;

   localparam logic [31:0] IFU_RESET_PC   = 32'h80000000;

   localparam logic [1:0]  FAULT_NONE     = 2'b00;
   localparam logic [1:0]  FAULT_ACCESS   = 2'b01;
   localparam logic [1:0]  FAULT_MISALIGN = 2'b10;

endpackage

// File: rtl/ysyx_23060203_ifu.sv
// Instruction fetch unit: issues one AXI4-Lite read per PC, hands the word to
// decode, then waits for the next PC from execute/writeback.
module ysyx_23060203_ifu
   import ysyx_23060203_ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
   input  logic        clk,
   input  logic        rstn,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic [1:0]  fault,
   output logic        out_valid,
   input  logic        out_ready,
   input  logic [31:0] npc,
   input  logic        npc_valid
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_OUT,
      S_NPC
   } state_t;

   state_t state, state_next;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= S_REQ;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_REQ:  if (arready)   state_next = S_WAIT;
         S_WAIT: if (rvalid)    state_next = S_OUT;
         S_OUT:  if (out_ready) state_next = S_NPC;
         S_NPC: begin
            // A misaligned target never reaches the bus; it is reported directly.
            if (npc_valid) state_next = (npc[1:0] == 2'b00) ? S_REQ : S_OUT;
         end
         default: state_next = S_REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc    <= RESET_PC;
         inst  <= 32'b0;
         fault <= FAULT_NONE;
      end else begin
         if (state == S_WAIT && rvalid) begin
            inst  <= rdata;
            fault <= (rresp != 2'b00) ? FAULT_ACCESS : FAULT_NONE;
         end
         if (state == S_NPC && npc_valid) begin
            pc <= npc;
            if (npc[1:0] != 2'b00) begin
               inst  <= 32'b0;
               fault <= FAULT_MISALIGN;
            end
         end
      end
   end

   assign araddr    = pc;
   assign arvalid   = (state == S_REQ);
   assign rready    = (state == S_WAIT);
   assign out_valid = (state == S_OUT);

endmodule

// File: tb/tb_ysyx_23060203_ifu.sv
// Directed bench for the fetch unit: drives the AXI read channel and decode
// handshake by hand and compares against hand-computed values.
module tb_ysyx_23060203_ifu;

   logic        clk;
   logic        rstn;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [1:0]  fault;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] npc;
   logic        npc_valid;

   int assert_count = 0;
   int fail_count   = 0;
   int ar_fires     = 0;
   int fires_before;

   ysyx_23060203_ifu dut (
      .clk       (clk),
      .rstn      (rstn),
      .araddr    (araddr),
      .arvalid   (arvalid),
      .arready   (arready),
      .rdata     (rdata),
      .rresp     (rresp),
      .rvalid    (rvalid),
      .rready    (rready),
      .inst      (inst),
      .pc        (pc),
      .fault     (fault),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .npc       (npc),
      .npc_valid (npc_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts address handshakes so the bench can prove only one request fires.
   always @(posedge clk) begin
      if (rstn && arvalid && arready) ar_fires++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assert_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic ar_rdy, input logic r_vld,
                                input logic [31:0] r_data, input logic [1:0] r_resp,
                                input logic o_rdy, input logic n_vld,
                                input logic [31:0] n_pc);
      arready   = ar_rdy;
      rvalid    = r_vld;
      rdata     = r_data;
      rresp     = r_resp;
      out_ready = o_rdy;
      npc_valid = n_vld;
      npc       = n_pc;
   endtask

   initial begin
      rstn = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
      #13;
      checkOutput("reset_pc",        pc,        32'h80000000);
      checkOutput("reset_inst",      inst,      32'h0);
      checkOutput("reset_fault",     fault,     2'b00);
      checkOutput("reset_rready",    rready,    1'b0);
      checkOutput("reset_out_valid", out_valid, 1'b0);

      // First cycle after release must already request the boot address.
      rstn = 1'b1;
      #1;
      checkOutput("boot_arvalid", arvalid, 1'b1);
      checkOutput("boot_araddr",  araddr,  32'h80000000);

      applyStimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
      tick();
      checkOutput("wait_arvalid", arvalid, 1'b0);
      checkOutput("wait_rready",  rready,  1'b1);
      applyStimulus(1'b0, 1'b1, 32'h00000413, 2'b00, 1'b0, 1'b0, 32'h0);
      tick();
      checkOutput("t1_out_valid", out_valid, 1'b1);
      checkOutput("t1_inst",      inst,      32'h00000413);
      checkOutput("t1_pc",        pc,        32'h80000000);
      checkOutput("t1_fault",     fault,     2'b00);
      checkOutput("t1_rready",    rready,    1'b0);

      // Decode stalls; a stray npc pulse and a stray rvalid must both be ignored.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, 32'hdeadbeef, 2'b10, 1'b0, (i == 1), 32'h80001234);
         tick();
         checkOutput("stall_out_valid", out_valid, 1'b1);
         checkOutput("stall_inst",      inst,      32'h00000413);
         checkOutput("stall_pc",        pc,        32'h80000000);
         checkOutput("stall_fault",     fault,     2'b00);
         checkOutput("stall_arvalid",   arvalid,   1'b0);
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'h0);
      tick();
      checkOutput("npc_out_valid", out_valid, 1'b0);
      checkOutput("npc_arvalid",   arvalid,   1'b0);
      checkOutput("npc_pc_kept",   pc,        32'h80000000);

      applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'h80000010);
      tick();
      checkOutput("jump_arvalid", arvalid, 1'b1);
      checkOutput("jump_araddr",  araddr,  32'h80000010);

      // Memory back-pressure: address must hold and only one handshake happens.
      fires_before = ar_fires;
      applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("hold_arvalid", arvalid, 1'b1);
         checkOutput("hold_araddr",  araddr,  32'h80000010);
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
      tick();
      checkOutput("hold_rready", rready, 1'b1);
      applyStimulus(1'b1, 1'b1, 32'h00100093, 2'b10, 1'b1, 1'b0, 32'h0);
      tick();
      checkOutput("hold_fires",      ar_fires - fires_before, 1);
      checkOutput("err_out_valid",   out_valid, 1'b1);
      checkOutput("err_fault",       fault,     2'b01);
      checkOutput("err_inst",        inst,      32'h00100093);
      checkOutput("err_pc",          pc,        32'h80000010);
      applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'h0);
      tick();
      checkOutput("fast_handoff", out_valid, 1'b0);

      applyStimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'h80000012);
      tick();
      checkOutput("mis_arvalid",   arvalid,   1'b0);
      checkOutput("mis_out_valid", out_valid, 1'b1);
      checkOutput("mis_fault",     fault,     2'b10);
      checkOutput("mis_pc",        pc,        32'h80000012);
      checkOutput("mis_inst",      inst,      32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'h80000020);
      tick();
      checkOutput("after_mis_araddr", araddr, 32'h80000020);

      // Reset while the read is outstanding, with the response arriving late.
      applyStimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
      tick();
      checkOutput("rst_pre_rready", rready, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
      #2;
      rstn = 1'b0;
      #1;
      checkOutput("rst_mid_pc",        pc,        32'h80000000);
      checkOutput("rst_mid_out_valid", out_valid, 1'b0);
      checkOutput("rst_mid_rready",    rready,    1'b0);
      checkOutput("rst_mid_fault",     fault,     2'b00);
      #3;
      rstn = 1'b1;
      applyStimulus(1'b0, 1'b1, 32'h0000cafe, 2'b00, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput("late_arvalid",   arvalid,   1'b1);
         checkOutput("late_out_valid", out_valid, 1'b0);
         checkOutput("late_inst",      inst,      32'h0);
         checkOutput("late_araddr",    araddr,    32'h80000000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               assert_count, fail_count);
      $finish;
   end

endmodule

// File: doc/ysyx_23060203_ifu.md
YSYX_23060203_IFU -- requirements
Module: ysyx_23060203_IFU

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h80000000: address of the first fetch after reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port araddr, output, 32: instruction read address (AXI4-Lite AR).
REQ-005 SHALL have port arvalid, output, 1: read request valid.
REQ-006 SHALL have port arready, input, 1: memory accepts request.
REQ-007 SHALL have port rdata, input, 32: returned instruction word.
REQ-008 SHALL have port rresp, input, 2: read response; 2'b00 is OKAY.
REQ-009 SHALL have port rvalid, input, 1: read data valid.
REQ-010 SHALL have port rready, output, 1: IFU accepts read data.
REQ-011 SHALL have port inst, output, 32: fetched instruction to IDU.
REQ-012 SHALL have port pc, output, 32: address of inst.
REQ-013 SHALL have port fault, output, 2: 00 none, 01 access fault, 10 misaligned PC.
REQ-014 SHALL have port out_valid, output, 1: inst/pc/fault valid to decode.
REQ-015 SHALL have port out_ready, input, 1: decode accepts instruction.
REQ-016 SHALL have port npc, input, 32: next PC from execute/writeback.
REQ-017 SHALL have port npc_valid, input, 1: npc valid, one-cycle pulse or level.

Function
REQ-018 SHALL implement FSM states S_REQ, S_WAIT, S_OUT, S_NPC.
REQ-019 S_REQ: arvalid=1 and araddr=pc; on arvalid&arready, go to S_WAIT; araddr SHALL hold stable until accepted.
REQ-020 S_WAIT: rready=1; on rvalid, latch inst<=rdata and fault<=(rresp!=0 ? 01 : 00), then go to S_OUT.
REQ-021 S_OUT: out_valid=1; inst/pc/fault SHALL hold stable; on out_valid&out_ready, go to S_NPC.
REQ-022 S_NPC: on npc_valid, pc<=npc; if npc[1:0]==0, go to S_REQ.
REQ-023 S_NPC with npc_valid and npc[1:0]!=0: no bus request; inst<=32'b0, fault<=10, go to S_OUT.
REQ-024 npc_valid outside S_NPC SHALL be ignored.
REQ-025 arvalid SHALL be 0 outside S_REQ, rready SHALL be 0 outside S_WAIT, and out_valid SHALL be 0 outside S_OUT.
REQ-026 rvalid outside S_WAIT SHALL be ignored; inst SHALL NOT change.
REQ-027 Minimum latency: arvalid SHALL be asserted in the first cycle after rstn rises.
REQ-028 Minimum latency: with arready=1 and rvalid one cycle after AR fire, out_valid SHALL rise 2 cycles after the first arvalid cycle.
REQ-029 out_valid and out_ready already high on entry to S_OUT SHALL complete the handoff in one cycle.
REQ-030 Only one outstanding read SHALL exist at any time.

Reset
REQ-031 rstn low SHALL immediately set state=S_REQ, pc=RESET_PC, inst=0, fault=00, arvalid=1 after release, rready=0, out_valid=0.
REQ-032 Reset mid-transaction SHALL abandon the read; a late rvalid after release SHALL be ignored while in S_REQ.

Structure
REQ-033 RESET_PC default and fault codes SHALL live in a shared params include (params/ifu.v), alongside the existing opcode/alu/csr params.
REQ-034 State encoding SHALL remain local to the module.
REQ-035 Block SHALL be flat; no sub-module.

Verification
REQ-036 Reset release, arready=1, rvalid next cycle with rdata=32'h00000413, rresp=0 -> araddr=32'h80000000, out_valid with inst=32'h00000413, pc=32'h80000000, fault=00.
REQ-037 arready held 0 for 5 cycles -> arvalid stays 1 and araddr is stable all 5 cycles; exactly one AR fire.
REQ-038 out_ready=0 for 4 cycles, npc_valid pulsed meanwhile -> outputs stable, pulse ignored, no new arvalid.
REQ-039 npc=32'h80000010 in S_NPC -> next araddr=32'h80000010.
REQ-040 npc=32'h80000012 -> no arvalid; out_valid with fault=10, pc=32'h80000012, inst=0.
REQ-041 Two further tests: rresp=2'b10 -> fault=01. rstn pulsed low during S_WAIT -> pc=RESET_PC, out_valid=0, a late rvalid is ignored.
